// File: rtl/bcd6_candidate_gen.sv
// Packed-BCD candidate producer: walks an inclusive BCD range, optionally skipping
// straight to the next value whose digits never decrease from MSD to LSD.
//
// state   | meaning
// IDLE    | waiting for start after reset
// RUN     | out_value holds a candidate, out_valid high
// DONE    | range exhausted or rejected; done sticky, accepts a new start
module bcd6_candidate_gen #(
    parameter int DIGITS = 6,
    parameter int CNT_W  = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] start_value,
    input  logic [4*DIGITS-1:0] end_value,
    input  logic                mono_skip,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_value,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [CNT_W-1:0]    count
);
    localparam int W = 4 * DIGITS;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]   state;
    logic         mono_q;
    logic [W-1:0] end_q;
    logic [W-1:0] load_value;
    logic [W-1:0] next_value;
    logic         range_bad;

    // Smallest non-decreasing value >= v: each digit is raised to the running max above it.
    function automatic logic [W-1:0] bcd_fill(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   run_max;
        r       = '0;
        run_max = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (v[4*i +: 4] > run_max) run_max = v[4*i +: 4];
            r[4*i +: 4] = run_max;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_bad(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Valid BCD words compare correctly as plain unsigned binary.
    always_comb begin
        range_bad  = bcd_bad(start_value) | bcd_bad(end_value);
        load_value = mono_skip ? bcd_fill(start_value) : start_value;
        next_value = bcd_inc(out_value);
        if (mono_q) next_value = bcd_fill(next_value);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            out_value <= '0;
            count     <= '0;
            err       <= 1'b0;
            mono_q    <= 1'b0;
            end_q     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        count  <= '0;
                        mono_q <= mono_skip;
                        err    <= 1'b0;
                        end_q  <= end_value;
                        if (range_bad) begin
                            state <= ST_DONE;
                            err   <= 1'b1;
                        end else if (load_value > end_value) begin
                            state <= ST_DONE;
                        end else begin
                            state     <= ST_RUN;
                            out_value <= load_value;
                        end
                    end
                end
                ST_RUN: begin
                    if (out_ready) begin
                        count <= count + CNT_W'(1);
                        if (out_value == end_q || next_value > end_q) begin
                            state <= ST_DONE;
                        end else begin
                            out_value <= next_value;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = (state == ST_RUN);
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_bcd6_candidate_gen.sv
// Bench for bcd6_candidate_gen: an integer-domain reference enumerates the expected
// candidates of each range and the DUT stream is compared against it every cycle.
module tb_bcd6_candidate_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mono_skip = 1'b0;
    logic        out_ready = 1'b0;
    logic [23:0] start_value = '0;
    logic [23:0] end_value = '0;
    logic        out_valid;
    logic        busy;
    logic        done;
    logic        err;
    logic [23:0] out_value;
    logic [19:0] count;

    int total = 0;
    int bad = 0;
    logic [23:0] exp_q[$];
    bit pat[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    bcd6_candidate_gen #(.DIGITS(6), .CNT_W(20)) dut (
        .clk(clk), .rst(rst), .start(start), .start_value(start_value),
        .end_value(end_value), .mono_skip(mono_skip), .out_valid(out_valid),
        .out_ready(out_ready), .out_value(out_value), .busy(busy), .done(done),
        .err(err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic int from_bcd(input logic [23:0] b);
        int r = 0;
        for (int i = 5; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit nondec(input int v);
        int x = v;
        int prev = 10;
        for (int i = 0; i < 6; i++) begin
            if (x % 10 > prev) return 1'b0;
            prev = x % 10;
            x = x / 10;
        end
        return 1'b1;
    endfunction

    function automatic bit has_bad(input logic [23:0] b);
        for (int i = 0; i < 6; i++) if (b[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // mode: 0 = ready always high, 1 = random ready plus stray starts, 2 = fixed ready pattern
    task automatic run_range(input logic [23:0] s, input logic [23:0] e, input bit mono,
                             input int mode, input int lit_cnt);
        int n, idx, cyc, budget;
        bit rdy, exp_err;
        exp_q.delete();
        exp_err = has_bad(s) || has_bad(e);
        if (!exp_err)
            for (int v = from_bcd(s); v <= from_bcd(e); v++)
                if (!mono || nondec(v)) exp_q.push_back(to_bcd(v));
        n = exp_q.size();
        if (lit_cnt >= 0) chk("model_len", n, lit_cnt);

        start_value = s; end_value = e; mono_skip = mono; out_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0; cyc = 0; budget = 20 * n + 50;
        while (idx < n && cyc < budget) begin
            chk("valid", out_valid, 1);
            chk("value", out_value, exp_q[idx]);
            chk("count_run", count, idx);
            chk("busy", busy, 1);
            chk("done_run", done, 0);
            case (mode)
                0: rdy = 1'b1;
                1: rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc < 6) ? pat[cyc] : 1'b1;
            endcase
            out_ready = rdy;
            if (mode == 1 && $urandom_range(0, 7) == 0) begin
                start = 1'b1;
                start_value = to_bcd($urandom_range(0, 999999));
                mono_skip = ~mono;
            end
            @(negedge clk);
            start = 1'b0; start_value = s; mono_skip = mono;
            if (rdy) idx++;
            cyc++;
        end
        if (idx < n) chk("timeout", idx, n);
        out_ready = 1'b0;
        chk("done", done, 1);
        chk("valid_done", out_valid, 0);
        chk("busy_done", busy, 0);
        chk("err", err, exp_err);
        chk("count_final", count, n);
        if (lit_cnt >= 0) chk("count_lit", count, lit_cnt);
        if (n > 0) chk("last_value", out_value, exp_q[n-1]);
        @(negedge clk);
        chk("done_sticky", done, 1);
        chk("count_held", count, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, si, ei, p;
        logic [23:0] sv, ev;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_value", out_value, 0);
        chk("rst_count", count, 0);
        rst = 1'b1;
        @(negedge clk);

        run_range(24'h000000, 24'h000012, 1'b0, 0, 13);
        run_range(24'h000098, 24'h000101, 1'b0, 0, 4);
        run_range(24'h123400, 24'h123460, 1'b1, 0, 11);
        chk("mono_first", exp_q[0], 24'h123444);
        chk("mono_seventh", exp_q[6], 24'h123455);
        run_range(24'h000005, 24'h000007, 1'b0, 2, 3);
        run_range(24'h0A0000, 24'h000100, 1'b0, 0, 0);
        run_range(24'h000050, 24'h000040, 1'b0, 0, 0);

        // asynchronous reset in the middle of a run
        start_value = 24'h000000; end_value = 24'h000010; mono_skip = 1'b0;
        out_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (out_value !== 24'h000003 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_3", out_value, 24'h000003);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", count, 0);
        @(negedge clk);
        chk("mid_rst_count_hold", count, 0);
        out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        run_range(24'h000001, 24'h000001, 1'b0, 0, 1);

        for (int k = 0; k < 30; k++) begin
            si = $urandom_range(0, 999990);
            ei = si + $urandom_range(0, 60) - 5;
            if (ei < 0) ei = 0;
            if (ei > 999999) ei = 999999;
            sv = to_bcd(si);
            ev = to_bcd(ei);
            if ($urandom_range(0, 9) == 0) begin
                p = $urandom_range(0, 5);
                if ($urandom_range(0, 1) == 1) sv[4*p +: 4] = 4'($urandom_range(10, 15));
                else ev[4*p +: 4] = 4'($urandom_range(10, 15));
            end
            run_range(sv, ev, 1'($urandom_range(0, 1)), $urandom_range(0, 1), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
